// File: rtl/pll_lock_manager.sv
// pll_lock_manager
//   Sequences reset, lock qualification and retry handling for up to four
//   SB_PLL40 instances, each channel with its own independent FSM.
//
// Ports
//   REFERENCECLK  free-running reference clock, the only clock
//   RESET         asynchronous active-low reset, released synchronously
//   ENABLE        per-channel enable (level)
//   LOCK_IN       raw PLL LOCK, asynchronous, synchronised internally
//   BYPASS_REQ    per-channel bypass request
//   CLEAR_FAULT   single-cycle pulse that returns a faulted channel to OFF
//   PLL_RESETB    active-low reset to each PLL
//   PLL_BYPASS    registered bypass control to each PLL
//   READY         channel clock usable
//   FAULT         lock retries exhausted
//   RETRY_CNT     attempts used, channel i at [4i+3:4i]
module pll_lock_manager #(
  parameter int unsigned N_CH           = 2,
  parameter int unsigned RST_CYCLES     = 4,
  parameter int unsigned FILTER_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic              REFERENCECLK,
  input  logic              RESET,
  input  logic [N_CH-1:0]   ENABLE,
  input  logic [N_CH-1:0]   LOCK_IN,
  input  logic [N_CH-1:0]   BYPASS_REQ,
  input  logic [N_CH-1:0]   CLEAR_FAULT,
  output logic [N_CH-1:0]   PLL_RESETB,
  output logic [N_CH-1:0]   PLL_BYPASS,
  output logic [N_CH-1:0]   READY,
  output logic [N_CH-1:0]   FAULT,
  output logic [4*N_CH-1:0] RETRY_CNT
);

  localparam int unsigned RW = $clog2(RST_CYCLES) + 1;
  localparam int unsigned FW = $clog2(FILTER_CYCLES) + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [2:0] {
    S_OFF, S_RST, S_WAIT, S_FILT, S_RUN, S_FLT
  } state_t;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic [1:0]    r_sync;
    logic          r_go;
    state_t        r_state;
    state_t        w_next;
    logic [RW-1:0] r_rst_cnt;
    logic [FW-1:0] r_filt_cnt;
    logic [TW-1:0] r_to_cnt;
    logic [3:0]    r_retry;
    logic          r_ready;
    logic          r_bypass;
    logic          w_lk;
    logic          w_rst_done;
    logic          w_filt_done;
    logic          w_timeout;
    logic          w_resetb;
    logic          w_ready;
    logic          w_fault;

    assign w_lk        = r_sync[1];
    assign w_rst_done  = (r_rst_cnt >= RW'(RST_CYCLES - 1));
    assign w_filt_done = (r_filt_cnt >= FW'(FILTER_CYCLES - 1));
    assign w_timeout   = (r_to_cnt >= TW'(TIMEOUT_CYCLES - 1));

    // r_go holds the FSM for the first edge after reset release, so the
    // earliest transition lands on the second edge.
    always_ff @(posedge REFERENCECLK or negedge RESET) begin
      if (!RESET) begin
        r_sync     <= '0;
        r_go       <= 1'b0;
        r_state    <= S_OFF;
        r_rst_cnt  <= '0;
        r_filt_cnt <= '0;
        r_to_cnt   <= '0;
        r_retry    <= '0;
        r_ready    <= 1'b0;
        r_bypass   <= 1'b0;
      end else begin
        r_sync  <= {r_sync[0], LOCK_IN[gi]};
        r_go    <= 1'b1;
        r_state <= w_next;
        r_ready <= r_go && (r_state == S_RUN) && (w_next == S_RUN);

        if (r_go && ((r_state == S_OFF) || (r_state == S_RUN)))
          r_bypass <= BYPASS_REQ[gi];

        if ((r_state == S_RST) && (w_next == S_RST))
          r_rst_cnt <= r_rst_cnt + 1'b1;
        else
          r_rst_cnt <= '0;

        if (w_next == S_FILT)
          r_filt_cnt <= (r_state == S_FILT) ? r_filt_cnt + 1'b1 : FW'(1);
        else
          r_filt_cnt <= '0;

        // Timeout keeps running across WAIT<->FILT bounces; saturates.
        if (((w_next == S_WAIT) || (w_next == S_FILT)) &&
            ((r_state == S_WAIT) || (r_state == S_FILT))) begin
          if (!w_timeout)
            r_to_cnt <= r_to_cnt + 1'b1;
        end else begin
          r_to_cnt <= '0;
        end

        // Enabling from OFF clears the count, and that entry is attempt 1.
        if ((w_next == S_RST) && (r_state != S_RST)) begin
          if (r_state == S_OFF)
            r_retry <= 4'd1;
          else if (r_retry != 4'hF)
            r_retry <= r_retry + 1'b1;
        end else if ((w_next == S_RUN) && (r_state != S_RUN)) begin
          r_retry <= '0;
        end
      end
    end

    always_comb begin
      w_next = r_state;
      if (!r_go) begin
        w_next = r_state;
      end else if ((r_state != S_FLT) && !ENABLE[gi]) begin
        w_next = S_OFF;
      end else begin
        case (r_state)
          S_OFF:  if (ENABLE[gi]) w_next = S_RST;
          S_RST:  if (w_rst_done) w_next = S_WAIT;
          S_WAIT: begin
            // Timeout wins over a lock arriving in the same cycle.
            if (w_timeout)
              w_next = (r_retry < 4'(MAX_RETRY)) ? S_RST : S_FLT;
            else if (w_lk)
              w_next = (FILTER_CYCLES == 1) ? S_RUN : S_FILT;
          end
          S_FILT: begin
            if (!w_lk)
              w_next = S_WAIT;
            else if (w_filt_done)
              w_next = S_RUN;
          end
          S_RUN:  if (!w_lk) w_next = S_RST;
          S_FLT:  if (CLEAR_FAULT[gi]) w_next = S_OFF;
          default: w_next = S_OFF;
        endcase
      end
    end

    // READY is masked by lk so it falls in the same cycle lock is lost.
    always_comb begin
      w_resetb = (r_state == S_WAIT) || (r_state == S_FILT) || (r_state == S_RUN);
      w_ready  = r_ready && w_lk;
      w_fault  = (r_state == S_FLT);
    end

    assign PLL_RESETB[gi]      = w_resetb;
    assign PLL_BYPASS[gi]      = r_bypass;
    assign READY[gi]           = w_ready;
    assign FAULT[gi]           = w_fault;
    assign RETRY_CNT[4*gi +: 4] = r_retry;
  end

endmodule
